// File: rtl/intersection_scheduler.sv
// Phase sequencer for a two-way intersection with a pedestrian crossing and a night-flash mode.
// All timing is counted in blink ticks; the light outputs are decoded from the registered phase.
module intersection_scheduler #(
  parameter int C_INT_GREEN  = 10,
  parameter int C_INT_YELLOW = 2,
  parameter int C_INT_ALLRED = 1,
  parameter int C_INT_WALK   = 5
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       blink,
  input  logic       inMode,
  input  logic       inTraffic,
  input  logic       inPedestrian,
  output logic [1:0] outLightNS,
  output logic [1:0] outLightEW,
  output logic       outWalk,
  output logic       outPedWait,
  output logic [2:0] outState
);

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_B  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  localparam logic [1:0] L_RED    = 2'd0;
  localparam logic [1:0] L_GREEN  = 2'd1;
  localparam logic [1:0] L_YELLOW = 2'd2;

  localparam logic [7:0] GREEN_LAST  = 8'(C_INT_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(C_INT_YELLOW - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(C_INT_ALLRED - 1);
  localparam logic [7:0] WALK_LAST   = 8'(C_INT_WALK - 1);

  state_t     state;
  state_t     nextState;
  logic [7:0] cnt;
  logic       carReq;
  logic       pedReq;
  logic       pedPrev;
  logic       flashPh;
  logic       pedEdge;

  assign pedEdge = inPedestrian & ~pedPrev;

  // Phase decisions happen only on a blink; night mode outranks request branches.
  always_comb begin
    nextState = state;
    if (blink) begin
      unique case (state)
        AR_A:  if (cnt == ALLRED_LAST) nextState = inMode ? FLASH : NS_G;
        NS_G:  if (inMode || (cnt >= GREEN_LAST && (carReq || pedReq))) nextState = NS_Y;
        NS_Y:  if (cnt == YELLOW_LAST) nextState = AR_B;
        AR_B:  if (cnt == ALLRED_LAST) begin
                 if (inMode)      nextState = FLASH;
                 else if (carReq) nextState = EW_G;
                 else if (pedReq) nextState = WALK;
                 else             nextState = AR_A;
               end
        EW_G:  if (inMode || cnt == GREEN_LAST) nextState = EW_Y;
        EW_Y:  if (cnt == YELLOW_LAST) nextState = (!inMode && pedReq) ? WALK : AR_A;
        WALK:  if (cnt == WALK_LAST) nextState = inMode ? FLASH : AR_A;
        FLASH: if (!inMode) nextState = AR_A;
      endcase
    end
  end

  // The counter saturates so an indefinitely held NS green keeps its minimum-green qualification.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= AR_A;
      cnt     <= '0;
      carReq  <= 1'b0;
      pedReq  <= 1'b0;
      pedPrev <= 1'b0;
      flashPh <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState != state)           cnt <= '0;
      else if (blink && cnt != 8'hFF)   cnt <= cnt + 8'd1;
      if (nextState == EW_G && state != EW_G) carReq <= 1'b0;
      else if (inTraffic)                     carReq <= 1'b1;
      if (nextState == WALK) pedReq <= 1'b0;
      else if (pedEdge)      pedReq <= 1'b1;
      pedPrev <= inPedestrian;
      if (nextState == FLASH && state != FLASH) flashPh <= 1'b0;
      else if (state == FLASH && blink)         flashPh <= ~flashPh;
    end
  end

  always_comb begin
    outLightNS = L_RED;
    outLightEW = L_RED;
    unique case (state)
      NS_G:  outLightNS = L_GREEN;
      NS_Y:  outLightNS = L_YELLOW;
      EW_G:  outLightEW = L_GREEN;
      EW_Y:  outLightEW = L_YELLOW;
      FLASH: begin
        outLightNS = flashPh ? L_YELLOW : L_RED;
        outLightEW = flashPh ? L_YELLOW : L_RED;
      end
      default: ;
    endcase
  end

  assign outWalk    = (state == WALK);
  assign outPedWait = pedReq;
  assign outState   = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: a vector table of phase checkpoints, an async-reset sequence,
// and randomized inputs compared every clock against a blink-counting reference model.
module tb_intersection_scheduler;

  localparam int GREEN  = 3;
  localparam int YELLOW = 2;
  localparam int ALLRED = 1;
  localparam int WALKD  = 2;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       blink = 1'b0;
  logic       inMode = 1'b0;
  logic       inTraffic = 1'b0;
  logic       inPedestrian = 1'b0;
  logic [1:0] outLightNS;
  logic [1:0] outLightEW;
  logic       outWalk;
  logic       outPedWait;
  logic [2:0] outState;

  intersection_scheduler #(
    .C_INT_GREEN(GREEN), .C_INT_YELLOW(YELLOW), .C_INT_ALLRED(ALLRED), .C_INT_WALK(WALKD)
  ) dut (
    .clk(clk), .rstb(rstb), .blink(blink), .inMode(inMode), .inTraffic(inTraffic),
    .inPedestrian(inPedestrian), .outLightNS(outLightNS), .outLightEW(outLightEW),
    .outWalk(outWalk), .outPedWait(outPedWait), .outState(outState)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int k = 0;

  // Reference model: phase index, blinks completed in the phase, request flags.
  int mPh;
  int mDone;
  bit mCar, mPed, mPrev, mFlash;
  int dur [8];

  task automatic modelReset();
    mPh = 0; mDone = 0; mCar = 0; mPed = 0; mPrev = 0; mFlash = 0;
  endtask

  task automatic modelClock(input bit m, input bit t, input bit p, input bit b);
    int nxt;
    int n;
    bit fin;
    nxt = mPh;
    if (b) begin
      n = mDone + 1;
      fin = (n == dur[mPh]);
      case (mPh)
        0: if (fin) nxt = m ? 7 : 1;
        1: if (m || (n >= GREEN && (mCar || mPed))) nxt = 2;
        2: if (fin) nxt = 3;
        3: if (fin) nxt = m ? 7 : (mCar ? 4 : (mPed ? 6 : 0));
        4: if (m || fin) nxt = 5;
        5: if (fin) nxt = (!m && mPed) ? 6 : 0;
        6: if (fin) nxt = m ? 7 : 0;
        default: if (!m) nxt = 0;
      endcase
      if (nxt == 7 && mPh != 7) mFlash = 0;
      else if (mPh == 7)        mFlash = !mFlash;
      mDone = (nxt != mPh) ? 0 : ((n > 255) ? 255 : n);
    end
    if (nxt == 4 && mPh != 4) mCar = 0;
    else if (t)               mCar = 1;
    if (nxt == 6)             mPed = 0;
    else if (p && !mPrev)     mPed = 1;
    mPrev = p;
    mPh = nxt;
  endtask

  function automatic logic [8:0] modelOut();
    logic [1:0] ns, ew;
    ns = (mPh == 1) ? 2'd1 : (mPh == 2) ? 2'd2 : (mPh == 7 && mFlash) ? 2'd2 : 2'd0;
    ew = (mPh == 4) ? 2'd1 : (mPh == 5) ? 2'd2 : (mPh == 7 && mFlash) ? 2'd2 : 2'd0;
    return {3'(mPh), ns, ew, (mPh == 6), mPed};
  endfunction

  function automatic logic [8:0] dutOut();
    return {outState, outLightNS, outLightEW, outWalk, outPedWait};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s k=%0d got st/ns/ew/w/pw=%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
               name, k, got[8:6], got[5:4], got[3:2], got[1], got[0],
               exp[8:6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input bit m, input bit t, input bit p);
    bit b;
    b = (k % 4 == 3);
    inMode = m; inTraffic = t; inPedestrian = p; blink = b;
    @(posedge clk);
    modelClock(m, t, p, b);
    #1;
    check("model", dutOut(), modelOut());
    k++;
  endtask

  typedef struct {
    bit m, t, p;
    int n;
    logic [2:0] st;
    logic [1:0] ns, ew;
    bit w, pw;
  } vec_t;

  vec_t tbl [30];

  task automatic setV(input int i, input bit m, input bit t, input bit p, input int n,
                      input logic [2:0] st, input logic [1:0] ns, input logic [1:0] ew,
                      input bit w, input bit pw);
    tbl[i].m = m; tbl[i].t = t; tbl[i].p = p; tbl[i].n = n;
    tbl[i].st = st; tbl[i].ns = ns; tbl[i].ew = ew; tbl[i].w = w; tbl[i].pw = pw;
  endtask

  initial begin
    bit rm, rt, rp;
    bit found;
    dur[0] = ALLRED; dur[1] = GREEN; dur[2] = YELLOW; dur[3] = ALLRED;
    dur[4] = GREEN;  dur[5] = YELLOW; dur[6] = WALKD; dur[7] = 0;

    //      idx m t p   n  st ns ew w pw
    setV( 0, 0,0,0,  1, 0, 0, 0, 0, 0);
    setV( 1, 0,0,0,  3, 1, 1, 0, 0, 0);
    setV( 2, 0,0,0, 80, 1, 1, 0, 0, 0);
    setV( 3, 0,1,0,  1, 1, 1, 0, 0, 0);
    setV( 4, 0,0,0,  3, 2, 2, 0, 0, 0);
    setV( 5, 0,0,0,  8, 3, 0, 0, 0, 0);
    setV( 6, 0,0,0,  4, 4, 0, 1, 0, 0);
    setV( 7, 0,0,0, 12, 5, 0, 2, 0, 0);
    setV( 8, 0,0,0,  8, 0, 0, 0, 0, 0);
    setV( 9, 0,0,0,  4, 1, 1, 0, 0, 0);
    setV(10, 0,0,1,  1, 1, 1, 0, 0, 1);
    setV(11, 0,0,0,  3, 1, 1, 0, 0, 1);
    setV(12, 0,0,0,  8, 2, 2, 0, 0, 1);
    setV(13, 0,0,0,  8, 3, 0, 0, 0, 1);
    setV(14, 0,0,0,  4, 6, 0, 0, 1, 0);
    setV(15, 0,0,0,  8, 0, 0, 0, 0, 0);
    setV(16, 0,0,0,  4, 1, 1, 0, 0, 0);
    setV(17, 0,1,1,  1, 1, 1, 0, 0, 1);
    setV(18, 0,0,1, 11, 2, 2, 0, 0, 1);
    setV(19, 0,0,1, 12, 4, 0, 1, 0, 1);
    setV(20, 0,0,1, 20, 6, 0, 0, 1, 0);
    setV(21, 0,0,1,  8, 0, 0, 0, 0, 0);
    setV(22, 0,0,0,  4, 1, 1, 0, 0, 0);
    setV(23, 1,0,0,  4, 2, 2, 0, 0, 0);
    setV(24, 1,0,0,  8, 3, 0, 0, 0, 0);
    setV(25, 1,0,0,  4, 7, 0, 0, 0, 0);
    setV(26, 1,0,0,  4, 7, 2, 2, 0, 0);
    setV(27, 1,0,0,  4, 7, 0, 0, 0, 0);
    setV(28, 0,0,0,  4, 0, 0, 0, 0, 0);
    setV(29, 0,0,0,  4, 1, 1, 0, 0, 0);

    modelReset();
    repeat (3) @(posedge clk);
    #1;
    check("reset", dutOut(), 9'd0);
    @(negedge clk);
    rstb = 1'b1;

    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < tbl[i].n; j++) step(tbl[i].m, tbl[i].t, tbl[i].p);
      check($sformatf("vec%0d", i), dutOut(),
            {tbl[i].st, tbl[i].ns, tbl[i].ew, tbl[i].w, tbl[i].pw});
    end

    // Async reset in the middle of EW yellow with a pedestrian request pending.
    step(0, 1, 1);
    step(0, 0, 0);
    found = 0;
    for (int j = 0; j < 400 && !found; j++) begin
      if (outState == 3'd5) found = 1;
      else step(0, 0, 0);
    end
    nChecks++;
    if (!found) begin
      nFails++;
      $display("FAIL reach_ew_y state=%0d required 5", outState);
    end
    check("pre_reset", dutOut(), {3'd5, 2'd0, 2'd2, 1'b0, 1'b1});
    #2 rstb = 1'b0;
    #1;
    check("async_reset", dutOut(), 9'd0);
    @(negedge clk);
    inPedestrian = 1'b0; inTraffic = 1'b0; inMode = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    modelReset();
    k = 0;
    step(0, 0, 0);
    check("restart_ar_a", dutOut(), 9'd0);
    for (int j = 0; j < 3; j++) step(0, 0, 0);
    check("restart_ns_g", dutOut(), {3'd1, 2'd1, 2'd0, 1'b0, 1'b0});

    // Randomized run against the reference model.
    rm = 0; rt = 0; rp = 0;
    for (int j = 0; j < 4000; j++) begin
      if ($urandom_range(299) == 0) rm = !rm;
      rt = ($urandom_range(39) == 0);
      if ($urandom_range(24) == 0) rp = !rp;
      step(rm, rt, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
